// File: rtl/ultra_sonic_ranger.sv
// ultra_sonic_ranger: HC-SR04 trigger/echo timing core; define ULTRA_SONIC_MEDIAN3_EN for a 3-result median filter
module ultra_sonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic [15:0] distance,
    output logic        distance_valid,
    output logic        timeout,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, presc_q, presc_d, presc_nx;
    logic [15:0] cm_q, cm_d, cm_nx, dist_q, dist_d;
    logic tflag_q, tflag_d, vld_q, vld_d, trig_q, wrap;
    logic s1_q, s2_q, s3_q, rise_q, fall_q;
    // Two-flop echo synchronizer, a history flop, and registered edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {s1_q, s2_q, s3_q, rise_q, fall_q} <= '0;
        end else begin
            s1_q   <= echo;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end
    assign wrap     = presc_q == CNT_W'(CYCLES_PER_CM - 1);
    assign presc_nx = wrap ? '0 : presc_q + CNT_W'(1);
    assign cm_nx    = (wrap && cm_q != 16'hFFFE) ? cm_q + 16'd1 : cm_q;
    // Next state; the fall cycle itself is counted so the width is measured in full
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        tflag_d = tflag_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE:      if (enable) state_d = TRIG;
            TRIG:      if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) state_d = WAIT_RISE;
            WAIT_RISE: begin
                if (rise_q) begin
                    state_d = MEASURE;
                    presc_d = '0;
                    cm_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = HOLDOFF;
                    dist_d  = 16'hFFFF;
                    tflag_d = 1'b1;
                    vld_d   = 1'b1;
                end
            end
            MEASURE: begin
                presc_d = presc_nx;
                cm_d    = cm_nx;
                if (fall_q) begin
                    state_d = HOLDOFF;
                    dist_d  = cm_nx;
                    tflag_d = 1'b0;
                    vld_d   = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = HOLDOFF;
                    dist_d  = 16'hFFFF;
                    tflag_d = 1'b1;
                    vld_d   = 1'b1;
                end
            end
            HOLDOFF:   if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) state_d = enable ? TRIG : IDLE;
            default:   state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    end
    // State, counters and raw result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            tflag_q <= 1'b0;
            vld_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            tflag_q <= tflag_d;
            vld_q   <= vld_d;
            trig_q  <= state_d == TRIG;
        end
    end
    assign trigger = trig_q;
    assign busy    = state_q != IDLE;
`ifdef ULTRA_SONIC_MEDIAN3_EN
    logic [15:0] w0_q, w1_q, out_q;
    logic [1:0]  n_q;
    logic        ovld_q, otmo_q;
    function automatic logic [15:0] med3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] lo, hi;
        lo = a < b ? a : b;
        hi = a < b ? b : a;
        return c < lo ? lo : (c > hi ? hi : c);
    endfunction
    // Median over the last three good results; timeouts bypass the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {w0_q, w1_q, out_q} <= '0;
            n_q    <= '0;
            ovld_q <= 1'b0;
            otmo_q <= 1'b0;
        end else begin
            ovld_q <= vld_q;
            if (vld_q) begin
                otmo_q <= tflag_q;
                out_q  <= tflag_q ? 16'hFFFF : (n_q == 2'd2 ? med3(dist_q, w0_q, w1_q) : dist_q);
                if (!tflag_q) begin
                    w0_q <= dist_q;
                    w1_q <= w0_q;
                    n_q  <= n_q == 2'd2 ? n_q : n_q + 2'd1;
                end
            end
        end
    end
    assign distance       = out_q;
    assign distance_valid = ovld_q;
    assign timeout        = otmo_q;
`else
    assign distance       = dist_q;
    assign distance_valid = vld_q;
    assign timeout        = tflag_q;
`endif
endmodule

// File: tb/tb_ultra_sonic_ranger.sv
// tb_ultra_sonic_ranger: directed scoreboard bench for the ultrasonic ranger
module tb_ultra_sonic_ranger;
    localparam int TRIG = 10, CPC = 4, TMO = 200, HOLD = 50;
`ifdef ULTRA_SONIC_MEDIAN3_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    logic clk = 0, reset = 1, enable = 0, echo = 0;
    logic trigger, distance_valid, timeout, busy;
    logic [15:0] distance;
    typedef struct {logic [15:0] d; logic t;} exp_t;
    exp_t q[$];
    exp_t e;
    int pass_n = 0, tot_n = 0, strobes = 0, strobe_cyc = 0, cyc = 0;
    int win0 = 0, win1 = 0, nwin = 0;

    ultra_sonic_ranger #(
        .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HOLD), .CNT_W(22)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trigger(trigger),
        .distance(distance), .distance_valid(distance_valid), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tot_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name);
        tot_n++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(posedge clk) begin
        #1;
        if (distance_valid) begin
            strobes++;
            strobe_cyc = cyc;
            if (q.size() == 0) begin
                tot_n++;
                $display("FAIL unexpected strobe: distance %0d with nothing expected", distance);
            end else begin
                e = q.pop_front();
                check("distance", int'(distance), int'(e.d));
                check("timeout flag", int'(timeout), int'(e.t));
            end
        end
    end

    function automatic int med(input int a, input int b, input int c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    task automatic push_good(input int raw);
        exp_t x;
        x.d = 16'(raw);
        x.t = 1'b0;
`ifdef ULTRA_SONIC_MEDIAN3_EN
        if (nwin >= 2) x.d = 16'(med(raw, win0, win1));
        win1 = win0;
        win0 = raw;
        if (nwin < 3) nwin++;
`endif
        q.push_back(x);
    endtask

    task automatic push_tmo();
        exp_t x;
        x.d = 16'hFFFF;
        x.t = 1'b1;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input int bound, output int c);
        int k = 0;
        while (trigger !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (trigger !== 1'b1) fail("trigger start");
        c = cyc;
    endtask

    task automatic trig_width(output int w);
        w = 0;
        while (trigger === 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic wait_strobe(input int bound);
        int s = strobes;
        int k = 0;
        while (strobes == s && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (strobes == s) fail("strobe wait");
    endtask

    // One full trigger/echo cycle; width 0 means no echo at all
    task automatic run(input int width, input int raw);
        int c, w, fc;
        wait_trig(HOLD + TRIG + 20, c);
        trig_width(w);
        check("trigger width", w, TRIG);
        fc = cyc;
        if (width == 0) begin
            push_tmo();
            wait_strobe(TMO + 20);
            check("rise timeout latency", strobe_cyc - fc, TMO);
        end else begin
            step(20);
            echo = 1;
            step(width);
            echo = 0;
            fc = cyc;
            push_good(raw);
            wait_strobe(HOLD);
            check("strobe latency", strobe_cyc - fc, LAT);
        end
    endtask

    initial begin
        int c, w, fc, hits;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, w, fc, hits;
        step(2);
        check("reset trigger", int'(trigger), 0);
        check("reset distance", int'(distance), 0);
        check("reset valid", int'(distance_valid), 0);
        check("reset timeout", int'(timeout), 0);
        check("reset busy", int'(busy), 0);
        reset = 0;
        step(3);
        check("idle busy", int'(busy), 0);
        check("idle trigger", int'(trigger), 0);
        enable = 1;
        run(0, 0);
        run(40, 10);
        run(43, 10);
        run(44, 11);
        // Echo stuck high: measurement times out, then exact holdoff to next trigger
        wait_trig(HOLD + TRIG + 20, c);
        trig_width(w);
        step(5);
        echo = 1;
        push_tmo();
        wait_strobe(TMO + 20);
        wait_trig(HOLD + 20, c);
        check("holdoff to trigger", c - strobe_cyc, HOLD);
        // Echo still high into WAIT_RISE is stale and must not start a measurement
        trig_width(w);
        fc = cyc;
        step(10);
        echo = 0;
        push_tmo();
        wait_strobe(TMO + 20);
        check("stale echo timeout latency", strobe_cyc - fc, TMO);
        // Enable dropped mid-measurement: completes, holds off, then idles
        wait_trig(HOLD + TRIG + 20, c);
        trig_width(w);
        step(20);
        echo = 1;
        step(10);
        enable = 0;
        step(22);
        echo = 0;
        push_good(8);
        wait_strobe(HOLD);
        step(10);
        check("busy in holdoff", int'(busy), 1);
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (trigger) hits++;
        end
        check("idle after disable busy", int'(busy), 0);
        check("no trigger after disable", hits, 0);
        // Reset in the middle of a trigger pulse
        enable = 1;
        wait_trig(10, c);
        step(4);
        reset = 1;
        #1;
        check("mid-trig reset trigger", int'(trigger), 0);
        check("mid-trig reset busy", int'(busy), 0);
        check("mid-trig reset distance", int'(distance), 0);
        check("mid-trig reset timeout", int'(timeout), 0);
        check("mid-trig reset valid", int'(distance_valid), 0);
        win0 = 0;
        win1 = 0;
        nwin = 0;
        @(negedge clk);
        reset = 0;
        run(40, 10);
        run(120, 30);
        run(80, 20);
        run(0, 0);
        run(48, 12);
        enable = 0;
        step(HOLD + 20);
        check("scoreboard drained", q.size(), 0);
        check("final idle busy", int'(busy), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
